fetch_decode: RTL and testbench

- Program-counter and instruction-decode front end for the 8-bit single-cycle processor.
- Holds the 32-bit PC and presents it to instruction memory.
- Decodes the returned instruction into the read-address, write-address and write-enable controls that drive the 8×8 register file, plus ALU and operand-mux controls.
- Computes the next PC, including jump and branch.
- Sits between instruction memory and the register file/ALU datapath, acting as the initiator of every register-file access.

---
 rtl/fetch_decode.sv | 117 +++++++++++
 tb/tb_fetch_decode.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// fetch_decode: PC register, instruction decode and next-PC logic for the 8-bit single-cycle core.
// Define BRANCH_EN to decode j (0x06) and beq (0x07); otherwise both are treated as illegal opcodes.
module fetch_decode #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      INSTRUCTION,
  input  logic             ZERO,
  input  logic             BUSYWAIT,
  output logic [PC_W-1:0]  PC,
  output logic             WRITE,
  output logic [2:0]       INADDRESS,
  output logic [2:0]       OUT1ADDRESS,
  output logic [2:0]       OUT2ADDRESS,
  output logic [7:0]       IMMEDIATE,
  output logic [2:0]       ALUOP,
  output logic             IMM_SEL,
  output logic             NEG_SEL,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] RETIRED
);

  localparam int unsigned OP_W = 8;

  localparam logic [OP_W-1:0] OP_LOADI = 8'h00;
  localparam logic [OP_W-1:0] OP_MOV   = 8'h01;
  localparam logic [OP_W-1:0] OP_ADD   = 8'h02;
  localparam logic [OP_W-1:0] OP_SUB   = 8'h03;
  localparam logic [OP_W-1:0] OP_AND   = 8'h04;
  localparam logic [OP_W-1:0] OP_OR    = 8'h05;
`ifdef BRANCH_EN
  localparam logic [OP_W-1:0] OP_J     = 8'h06;
  localparam logic [OP_W-1:0] OP_BEQ   = 8'h07;
`endif

  localparam logic [2:0] ALU_FWD = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  logic [OP_W-1:0] opcode;
  logic            dec_write;
  logic            dec_illegal;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] pc_next;
`ifdef BRANCH_EN
  logic            take_target;
  logic [PC_W-1:0] branch_off;
  logic [PC_W-1:0] pc_target;
  logic            unused_c;
`else
  logic            unused_c;
`endif

  // Register-file fields are raw bit slices, independent of opcode
  assign opcode      = INSTRUCTION[31:24];
  assign INADDRESS   = INSTRUCTION[18:16];
  assign OUT1ADDRESS = INSTRUCTION[10:8];
  assign OUT2ADDRESS = INSTRUCTION[2:0];
  assign IMMEDIATE   = INSTRUCTION[7:0];

  // Opcode decode
  always_comb begin
    dec_write   = 1'b0;
    dec_illegal = 1'b0;
    ALUOP       = ALU_FWD;
    IMM_SEL     = 1'b0;
    NEG_SEL     = 1'b0;
`ifdef BRANCH_EN
    take_target = 1'b0;
`endif
    case (opcode)
      OP_LOADI: begin dec_write = 1'b1; IMM_SEL = 1'b1; end
      OP_MOV:   dec_write = 1'b1;
      OP_ADD:   begin dec_write = 1'b1; ALUOP = ALU_ADD; end
      OP_SUB:   begin dec_write = 1'b1; ALUOP = ALU_ADD; NEG_SEL = 1'b1; end
      OP_AND:   begin dec_write = 1'b1; ALUOP = ALU_AND; end
      OP_OR:    begin dec_write = 1'b1; ALUOP = ALU_OR; end
`ifdef BRANCH_EN
      OP_J:     take_target = 1'b1;
      OP_BEQ:   begin ALUOP = ALU_ADD; NEG_SEL = 1'b1; take_target = ZERO; end
`endif
      default:  dec_illegal = 1'b1;
    endcase
  end

  // A write is never issued in a reset or stalled cycle
  assign WRITE    = dec_write & ~RESET & ~BUSYWAIT;
  assign pc_plus4 = PC + PC_W'(4);

`ifdef BRANCH_EN
  // Word offset from INSTRUCTION[23:16], sign-extended and scaled by 4
  assign branch_off = {{(PC_W-10){INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
  assign pc_target  = pc_plus4 + branch_off;
  assign pc_next    = take_target ? pc_target : pc_plus4;
  assign unused_c   = ^INSTRUCTION[15:11];
`else
  assign pc_next    = pc_plus4;
  assign unused_c   = ^{ZERO, INSTRUCTION[23:19], INSTRUCTION[15:11]};
`endif

  // Architectural state: reset beats stall beats retire
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC      <= '0;
      ILLEGAL <= 1'b0;
      RETIRED <= '0;
    end else if (!BUSYWAIT) begin
      PC      <= pc_next;
      ILLEGAL <= ILLEGAL | dec_illegal;
      RETIRED <= RETIRED + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed vectors pushed to a scoreboard queue; a monitor checks decode mid-cycle
// and PC/RETIRED/ILLEGAL just after each rising edge.
module tb_fetch_decode;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [31:0]      INSTRUCTION = 32'h0;
  logic             ZERO = 1'b0;
  logic             BUSYWAIT = 1'b0;
  logic [PC_W-1:0]  PC;
  logic             WRITE;
  logic [2:0]       INADDRESS;
  logic [2:0]       OUT1ADDRESS;
  logic [2:0]       OUT2ADDRESS;
  logic [7:0]       IMMEDIATE;
  logic [2:0]       ALUOP;
  logic             IMM_SEL;
  logic             NEG_SEL;
  logic             ILLEGAL;
  logic [CNT_W-1:0] RETIRED;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic        ew;
    logic [2:0]  ealu;
    logic        eimm;
    logic        eneg;
    logic [31:0] epc;
    logic [15:0] eret;
    logic        eill;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_busy = 1'b0;

  always #5 CLK = ~CLK;

  fetch_decode #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO), .BUSYWAIT(BUSYWAIT),
    .PC(PC), .WRITE(WRITE), .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS), .IMMEDIATE(IMMEDIATE), .ALUOP(ALUOP), .IMM_SEL(IMM_SEL),
    .NEG_SEL(NEG_SEL), .ILLEGAL(ILLEGAL), .RETIRED(RETIRED)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", nm, fld, act, exp, $time);
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the DUT must show
  task automatic step(input string nm, input logic [31:0] ins, input logic z, input logic bw,
                      input logic rst, input logic ew, input logic [2:0] ealu, input logic eimm,
                      input logic eneg, input logic [31:0] epc, input logic [15:0] eret,
                      input logic eill);
    exp_t e;
    @(negedge CLK);
    INSTRUCTION = ins;
    ZERO        = z;
    BUSYWAIT    = bw;
    RESET       = rst;
    e.nm = nm; e.ins = ins; e.ew = ew; e.ealu = ealu; e.eimm = eimm; e.eneg = eneg;
    e.epc = epc; e.eret = eret; e.eill = eill;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        mon_busy = 1'b1;
        chk(e.nm, "WRITE",       32'(WRITE),       32'(e.ew));
        chk(e.nm, "ALUOP",       32'(ALUOP),       32'(e.ealu));
        chk(e.nm, "IMM_SEL",     32'(IMM_SEL),     32'(e.eimm));
        chk(e.nm, "NEG_SEL",     32'(NEG_SEL),     32'(e.eneg));
        chk(e.nm, "INADDRESS",   32'(INADDRESS),   32'(e.ins[18:16]));
        chk(e.nm, "OUT1ADDRESS", 32'(OUT1ADDRESS), 32'(e.ins[10:8]));
        chk(e.nm, "OUT2ADDRESS", 32'(OUT2ADDRESS), 32'(e.ins[2:0]));
        chk(e.nm, "IMMEDIATE",   32'(IMMEDIATE),   32'(e.ins[7:0]));
        @(posedge CLK);
        #1;
        chk(e.nm, "PC",      32'(PC),      e.epc);
        chk(e.nm, "RETIRED", 32'(RETIRED), 32'(e.eret));
        chk(e.nm, "ILLEGAL", 32'(ILLEGAL), 32'(e.eill));
        mon_busy = 1'b0;
      end
    end
  end

  // Driver: name, instr, ZERO, BUSYWAIT, RESET | WRITE, ALUOP, IMM_SEL, NEG_SEL | PC, RETIRED, ILLEGAL after edge
  initial begin
    step("reset",   32'h00020005, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'd0,  16'd0, 1'b0);
    step("loadi",   32'h00020005, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'd4,  16'd1, 1'b0);
    step("mov",     32'h01010300, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'd8,  16'd2, 1'b0);
    step("add",     32'h02050607, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 32'd12, 16'd3, 1'b0);
    for (int i = 0; i < 3; i++)
      step("stall", 32'h03040201, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 32'd12, 16'd3, 1'b0);
    step("sub",     32'h03040201, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 32'd16, 16'd4, 1'b0);
    step("and",     32'h04010203, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 32'd20, 16'd5, 1'b0);
    step("or",      32'h05020304, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 32'd24, 16'd6, 1'b0);
    step("illegal", 32'h09000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd28, 16'd7, 1'b1);
    step("sticky",  32'h00010001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'd32, 16'd8, 1'b1);
`ifdef BRANCH_EN
    step("j_to8",   32'h06F90000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd8,  16'd9,  1'b1);
    step("j_m2",    32'h06FE0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd4,  16'd10, 1'b1);
    step("j_0",     32'h06000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd8,  16'd11, 1'b1);
    step("beq_tk",  32'h07030102, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 32'd24, 16'd12, 1'b1);
    step("j_back",  32'h06FB0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd8,  16'd13, 1'b1);
    step("beq_nt",  32'h07030102, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 32'd12, 16'd14, 1'b1);
`else
    step("j_ill",   32'h06F90000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd36, 16'd9,  1'b1);
    step("beq_ill", 32'h07030102, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd40, 16'd10, 1'b1);
`endif
    step("rst_bw",  32'h03040201, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 32'd0,  16'd0, 1'b0);
`ifdef BRANCH_EN
    step("pc_low",  32'h06FE0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'hFFFFFFFC, 16'd1, 1'b0);
    step("pc_wrap", 32'h00030007, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'd0,  16'd2, 1'b0);
`endif
    step("rst_abort", 32'h00020005, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'd0, 16'd0, 1'b0);
    // Run the retire counter through its wrap to zero
    for (int i = 0; i < 65536; i++)
      step("ret_run", 32'h01000000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0,
           32'(4 * (i + 1)), 16'(i + 1), 1'b0);

    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (q.size() == 0 && !mon_busy) break;
    end
    if (q.size() != 0 || mon_busy) begin
      n_chk++;
      $display("FAIL drain: %0d entries still queued, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
